// File: rtl/alu_control_sequencer.sv
// Fetch/execute sequencer driving datapath strobes for three-operand ALU instructions (T0..T5).
// Latency: Start -> T0 next cycle; 6 cycles per instruction plus one per MemReady wait cycle in T1.
// Backpressure: MemReady stalls T1 up to MEM_TIMEOUT cycles; Start is ignored outside IDLE/T5.
module alu_control_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int REG_SEL_W   = 4,
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  MemReady,
  output logic                  PCout,
  output logic                  ZLOout,
  output logic                  MDRout,
  output logic                  MARin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Zin,
  output logic                  IncrementPC,
  output logic                  Read,
  output logic [NUM_REGS-1:0]   Rout,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [4:0]            ALUControl,
  output logic                  Busy,
  output logic                  Done,
  output logic                  IllegalOp,
  output logic                  BusError,
  output logic [CNT_W-1:0]      InstrCount
);

  // IR field positions: 5-bit opcode at the top, then Ra, Rb, Rc packed below it.
  localparam int RA_MSB  = DATA_WIDTH - 6;
  localparam int RB_MSB  = RA_MSB - REG_SEL_W;
  localparam int RC_MSB  = RB_MSB - REG_SEL_W;
  localparam int LOW_MSB = RC_MSB - REG_SEL_W;
  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

  localparam logic [REG_SEL_W:0] NREGS      = (REG_SEL_W + 1)'(NUM_REGS);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [4:0]         OP_MAX     = 5'b01011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  t1_first;
  logic                  legal_q;
  logic                  timeout_hit;
  logic                  illegal_hit;
  logic                  enter_t1;

  logic [4:0]            op;
  logic [REG_SEL_W-1:0]  ra;
  logic [REG_SEL_W-1:0]  rb;
  logic [REG_SEL_W-1:0]  rc;
  logic                  ir_legal;
  logic                  unused_ir_low;

  assign op  = IR[DATA_WIDTH-1 -: 5];
  assign ra  = IR[RA_MSB -: REG_SEL_W];
  assign rb  = IR[RB_MSB -: REG_SEL_W];
  assign rc  = IR[RC_MSB -: REG_SEL_W];

  // Bits below Rc carry no meaning for this instruction format.
  assign unused_ir_low = ^IR[LOW_MSB:0];

  // An instruction is accepted only if the opcode is implemented and every register index exists.
  assign ir_legal = (op <= OP_MAX) &&
                    ({1'b0, ra} < NREGS) &&
                    ({1'b0, rb} < NREGS) &&
                    ({1'b0, rc} < NREGS);

  // First T1 cycle is the only one allowed to bump the PC.
  assign enter_t1 = (state_nxt == S_T1) && (state != S_T1);

  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [REG_SEL_W-1:0] idx);
    sel_onehot = NUM_REGS'(1) << idx;
  endfunction

  // Next-state selection; MemReady wins over the timeout in the last permitted T1 cycle.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    illegal_hit = 1'b0;
    case (state)
      S_IDLE: if (Start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1: begin
        if (MemReady) begin
          state_nxt = S_T2;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (legal_q) begin
          state_nxt = S_T4;
        end else begin
          state_nxt   = S_IDLE;
          illegal_hit = 1'b1;
        end
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = Start ? S_T0 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, bookkeeping and registered Moore outputs decoded from the state being entered.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      t1_first    <= 1'b0;
      legal_q     <= 1'b0;
      InstrCount  <= '0;
      PCout       <= 1'b0;
      ZLOout      <= 1'b0;
      MDRout      <= 1'b0;
      MARin       <= 1'b0;
      PCin        <= 1'b0;
      MDRin       <= 1'b0;
      IRin        <= 1'b0;
      Yin         <= 1'b0;
      Zin         <= 1'b0;
      IncrementPC <= 1'b0;
      Read        <= 1'b0;
      Rout        <= '0;
      Rin         <= '0;
      ALUControl  <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      IllegalOp   <= 1'b0;
      BusError    <= 1'b0;
    end else begin
      state <= state_nxt;

      // T1 dwell counter: 1 in the first T1 cycle, counting up while memory stalls.
      if (state_nxt == S_T1) begin
        wait_cnt <= (state == S_T1) ? wait_cnt + 1'b1 : WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      t1_first <= enter_t1;

      // Legality is frozen at the T2->T3 edge so T3 strobes and the T3 exit agree.
      if (state_nxt == S_T3) begin
        legal_q <= ir_legal;
      end

      if (state == S_T5) begin
        InstrCount <= InstrCount + 1'b1;
      end

      PCout       <= 1'b0;
      ZLOout      <= 1'b0;
      MDRout      <= 1'b0;
      MARin       <= 1'b0;
      PCin        <= 1'b0;
      MDRin       <= 1'b0;
      IRin        <= 1'b0;
      Yin         <= 1'b0;
      Zin         <= 1'b0;
      IncrementPC <= 1'b0;
      Read        <= 1'b0;
      Rout        <= '0;
      Rin         <= '0;
      ALUControl  <= '0;
      Done        <= 1'b0;
      Busy        <= (state_nxt != S_IDLE);
      IllegalOp   <= illegal_hit;
      BusError    <= timeout_hit;

      case (state_nxt)
        S_T0: begin
          PCout <= 1'b1;
          MARin <= 1'b1;
          Zin   <= 1'b1;
        end
        S_T1: begin
          ZLOout      <= 1'b1;
          Read        <= 1'b1;
          MDRin       <= 1'b1;
          PCin        <= enter_t1;
          IncrementPC <= enter_t1;
        end
        S_T2: begin
          MDRout <= 1'b1;
          IRin   <= 1'b1;
        end
        S_T3: begin
          if (ir_legal) begin
            Rout <= sel_onehot(rb);
            Yin  <= 1'b1;
          end
        end
        S_T4: begin
          Rout       <= sel_onehot(rc);
          Zin        <= 1'b1;
          ALUControl <= op;
        end
        S_T5: begin
          ZLOout <= 1'b1;
          Rin    <= sel_onehot(ra);
          Done   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // The first-cycle flag mirrors the PC strobes; kept so a long T1 stall is easy to trace.
  logic unused_t1_first;
  assign unused_t1_first = t1_first;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: per-cycle strobe checks with hand-computed vectors.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// InstrCount is built 2 bits wide so the wrap case is reachable quickly.
module tb_alu_control_sequencer;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int RW = 4;
  localparam int MT = 8;
  localparam int CW = 2;

  logic           Clock = 1'b0;
  logic           Clear;
  logic           Start;
  logic [DW-1:0]  IR;
  logic           MemReady;
  logic           PCout, ZLOout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
  logic           IncrementPC, Read, Busy, Done, IllegalOp, BusError;
  logic [NR-1:0]  Rout, Rin;
  logic [4:0]     ALUControl;
  logic [CW-1:0]  InstrCount;

  // Control word bit order: PCout ZLOout MDRout MARin PCin MDRin IRin Yin Zin IncrementPC Read Done
  logic [31:0]    ctl;
  assign ctl = {20'd0, PCout, ZLOout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
                IncrementPC, Read, Done};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected per-cycle values for IR=0x28918000 with no wait states (T0..T5, then IDLE).
  logic [31:0] b_ctl  [7] = '{32'h908, 32'h4C6, 32'h220, 32'h010, 32'h008, 32'h401, 32'h000};
  logic [31:0] b_rout [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'h0, 32'h0};
  logic [31:0] b_rin  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h0};
  logic [31:0] b_alu  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0};
  logic [31:0] ill_ir [2] = '{32'hF800_0000, 32'h6000_0000};

  alu_control_sequencer #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .REG_SEL_W  (RW),
    .MEM_TIMEOUT(MT),
    .CNT_W      (CW)
  ) dut (
    .Clock      (Clock),
    .Clear      (Clear),
    .Start      (Start),
    .IR         (IR),
    .MemReady   (MemReady),
    .PCout      (PCout),
    .ZLOout     (ZLOout),
    .MDRout     (MDRout),
    .MARin      (MARin),
    .PCin       (PCin),
    .MDRin      (MDRin),
    .IRin       (IRin),
    .Yin        (Yin),
    .Zin        (Zin),
    .IncrementPC(IncrementPC),
    .Read       (Read),
    .Rout       (Rout),
    .Rin        (Rin),
    .ALUControl (ALUControl),
    .Busy       (Busy),
    .Done       (Done),
    .IllegalOp  (IllegalOp),
    .BusError   (BusError),
    .InstrCount (InstrCount)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " ctl"}, ctl, 32'h0);
    check_eq({tag, " rout"}, 32'(Rout), 32'h0);
    check_eq({tag, " rin"}, 32'(Rin), 32'h0);
    check_eq({tag, " alu"}, 32'(ALUControl), 32'h0);
    check_eq({tag, " busy/ill/berr"}, {29'd0, Busy, IllegalOp, BusError}, 32'h0);
  endtask

  initial begin
    int t1n;
    int ben;
    int illn;
    int busyn;
    int donen;

    Clear    = 1'b0;
    Start    = 1'b0;
    MemReady = 1'b0;
    IR       = '0;

    // Power-on reset.
    step();
    step();
    check_idle("reset");
    check_eq("reset count", 32'(InstrCount), 32'h0);
    Clear = 1'b1;
    step();

    // Basic instruction, no wait states.
    IR       = 32'h2891_8000;
    MemReady = 1'b1;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("basic ctl c%0d", i + 1), ctl, b_ctl[i]);
      check_eq($sformatf("basic rout c%0d", i + 1), 32'(Rout), b_rout[i]);
      check_eq($sformatf("basic rin c%0d", i + 1), 32'(Rin), b_rin[i]);
      check_eq($sformatf("basic alu c%0d", i + 1), 32'(ALUControl), b_alu[i]);
      check_eq($sformatf("basic busy c%0d", i + 1), 32'(Busy), (i < 6) ? 32'h1 : 32'h0);
      if (i < 6) step();
    end
    check_eq("basic count", 32'(InstrCount), 32'h1);

    // Three MemReady-low cycles: T1 lasts 4 cycles, Done at cycle 9 after the Start edge.
    cyc      = 0;
    MemReady = 1'b0;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    check_eq("wait T0 ctl", ctl, 32'h908);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) MemReady = 1'b1;
      check_eq($sformatf("wait T1 ctl c%0d", c), ctl, (c == 1) ? 32'h4C6 : 32'h442);
    end
    step();
    check_eq("wait T2 ctl", ctl, 32'h220);
    step();
    step();
    step();
    check_eq("wait done", 32'(Done), 32'h1);
    check_eq("wait done cycle", 32'(cyc), 32'd9);
    step();
    check_eq("wait berr", 32'(BusError), 32'h0);
    check_eq("wait count", 32'(InstrCount), 32'h2);

    // Timeout: MemReady never arrives.
    MemReady = 1'b0;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    t1n = 0;
    ben = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (Read) t1n++;
      if (BusError) ben++;
      if (!Busy) break;
    end
    check_eq("timeout T1 cycles", 32'(t1n), 32'd8);
    check_eq("timeout berr pulses", 32'(ben), 32'd1);
    step();
    check_eq("timeout berr cleared", 32'(BusError), 32'h0);
    check_eq("timeout busy", 32'(Busy), 32'h0);
    check_eq("timeout count", 32'(InstrCount), 32'h2);

    // Illegal opcodes: all-ones and the first unimplemented code.
    MemReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      IR    = ill_ir[k];
      Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      step();
      step();
      check_eq($sformatf("illegal%0d T3 ctl", k), ctl, 32'h0);
      check_eq($sformatf("illegal%0d T3 rout", k), 32'(Rout), 32'h0);
      illn = IllegalOp ? 1 : 0;
      step();
      if (IllegalOp) illn++;
      check_eq($sformatf("illegal%0d pulses", k), 32'(illn), 32'd1);
      check_eq($sformatf("illegal%0d after ctl", k), ctl, 32'h0);
      check_eq($sformatf("illegal%0d after rin", k), 32'(Rin), 32'h0);
      check_eq($sformatf("illegal%0d busy", k), 32'(Busy), 32'h0);
      step();
      check_eq($sformatf("illegal%0d pulse end", k), 32'(IllegalOp), 32'h0);
      check_eq($sformatf("illegal%0d count", k), 32'(InstrCount), 32'h2);
    end

    // Highest legal opcode with all registers R0.
    IR    = 32'h5800_0000;
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    step();
    check_eq("oplimit T3 ctl", ctl, 32'h010);
    check_eq("oplimit T3 rout", 32'(Rout), 32'h1);
    step();
    check_eq("oplimit T4 alu", 32'(ALUControl), 32'h0B);
    check_eq("oplimit T4 rout", 32'(Rout), 32'h1);
    step();
    check_eq("oplimit T5 rin", 32'(Rin), 32'h1);
    step();
    check_eq("oplimit count", 32'(InstrCount), 32'h3);

    // Clear held low for two cycles while in T4; Start asserted during Clear is ignored.
    IR    = 32'h2891_8000;
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    step();
    step();
    check_eq("midreset in T4", ctl, 32'h008);
    Clear = 1'b0;
    step();
    check_idle("midreset c1");
    check_eq("midreset count", 32'(InstrCount), 32'h0);
    Start = 1'b1;
    step();
    check_idle("midreset c2");
    Start = 1'b0;
    Clear = 1'b1;
    step();
    check_eq("midreset stays idle", 32'(Busy), 32'h0);

    // Back-to-back: three instructions with Start held.
    Start = 1'b1;
    step();
    busyn = 0;
    donen = 0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 13) Start = 1'b0;
      if (Busy) busyn++;
      if (Done) begin
        donen++;
        check_eq("b2b done spacing", 32'(c), 32'(6 * donen));
      end
      step();
    end
    check_eq("b2b busy cycles", 32'(busyn), 32'd18);
    check_eq("b2b done pulses", 32'(donen), 32'd3);
    check_eq("b2b idle after", 32'(Busy), 32'h0);
    check_eq("b2b count", 32'(InstrCount), 32'h3);

    // One more completion wraps the 2-bit counter.
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("wrap busy", 32'(Busy), 32'h0);
    check_eq("wrap count", 32'(InstrCount), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
